// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, memory-state and coherence-controller state types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [2:0] {IDLE, INV, SNOOP, LOAD, FWD, WB} coh_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_gid,
  output logic          o_valid
);
  logic [IW-1:0] w_k;
  // scan downward so the closest request to ptr is the last one written
  always_comb begin
    o_gid   = '0;
    o_valid = 1'b0;
    w_k     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_k = IW'((int'(i_ptr) + i) % N);
      if (i_req[w_k]) begin
        o_gid   = w_k;
        o_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: MSI snooping bus controller serialising L1 block transfers
module coherence_bus_ctrl
  import cpu_types_pkg::*;
#(
  parameter int NCPU      = 2,
  parameter int BLK_WORDS = 2,
  parameter int SNP_LAT   = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NCPU-1:0]      dREN,
  input  logic [NCPU-1:0]      dWEN,
  input  logic [NCPU-1:0][31:0] daddr,
  input  logic [NCPU-1:0][31:0] dstore,
  input  logic [NCPU-1:0]      cctrans,
  input  logic [NCPU-1:0]      ccwrite,
  input  logic [31:0]          ramload,
  input  ramstate_t            ramstate,
  output logic [NCPU-1:0]      dwait,
  output logic [NCPU-1:0][31:0] dload,
  output logic [NCPU-1:0]      ccwait,
  output logic [NCPU-1:0]      ccinv,
  output logic [NCPU-1:0][31:0] ccsnoopaddr,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore
);
  localparam int IDW = (NCPU > 1) ? $clog2(NCPU) : 1;
  localparam int CW  = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;

  coh_state_t     r_state;
  logic [IDW-1:0] r_grant, r_rr_ptr, r_sup;
  logic [CW-1:0]  r_wcnt;
  logic [2:0]     r_snp_cnt;

  logic [NCPU-1:0] w_req, w_others, w_hits;
  logic [IDW-1:0]  w_gid, w_hit_id;
  logic            w_gvalid, w_access, w_fwd_wr, w_done, w_last;

  assign w_req       = cctrans & (dREN | dWEN | ccwrite);
  assign w_others    = ~(NCPU'(1) << r_grant);
  assign w_hits      = cctrans & w_others;
  assign w_access    = ramstate == ACCESS;
  assign w_fwd_wr    = ccwrite[r_grant];
  assign w_done      = (r_state == FWD && w_fwd_wr) || ((r_state == LOAD || r_state == FWD || r_state == WB) && w_access);
  assign w_last      = r_wcnt == CW'(BLK_WORDS - 1);
  assign ccsnoopaddr = {NCPU{daddr[r_grant]}};

  rr_arbiter #(.N(NCPU), .IW(IDW)) u_arb (
    .i_req  (w_req),
    .i_ptr  (r_rr_ptr),
    .o_gid  (w_gid),
    .o_valid(w_gvalid)
  );

  // lowest-numbered snooped cache holding the line in M becomes the supplier
  always_comb begin
    w_hit_id = '0;
    for (int i = NCPU - 1; i >= 0; i--) w_hit_id = w_hits[i] ? IDW'(i) : w_hit_id;
  end

  // transaction sequencer: arbitrate, snoop, then move one block word per completion
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_sup     <= '0;
      r_wcnt    <= '0;
      r_snp_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_gvalid) begin
          r_grant   <= w_gid;
          r_rr_ptr  <= (w_gid == IDW'(NCPU - 1)) ? '0 : w_gid + 1'b1;
          r_wcnt    <= '0;
          r_snp_cnt <= '0;
          r_state   <= dWEN[w_gid] ? WB : dREN[w_gid] ? SNOOP : INV;
        end
        INV: r_state <= IDLE;
        SNOOP: if (r_snp_cnt == 3'(SNP_LAT)) begin
          r_sup   <= w_hit_id;
          r_state <= |w_hits ? FWD : LOAD;
        end else r_snp_cnt <= r_snp_cnt + 1'b1;
        default: if (w_done) begin
          r_wcnt <= w_last ? '0 : r_wcnt + 1'b1;
          if (w_last) r_state <= IDLE;
        end
      endcase
    end
  end

  // bus outputs decoded from the current phase and memory handshake
  always_comb begin
    dwait    = '1;
    dload    = '0;
    ccwait   = '0;
    ccinv    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (r_state)
      INV: ccinv = w_others;
      SNOOP: begin
        ccwait = w_others;
        ccinv  = w_fwd_wr ? w_others : '0;
      end
      LOAD: begin
        ccwait         = w_others;
        ramREN         = 1'b1;
        ramaddr        = daddr[r_grant];
        dload[r_grant] = ramload;
        dwait[r_grant] = !w_access;
      end
      FWD: begin
        ccwait         = w_others;
        dload[r_grant] = dstore[r_sup];
        ramWEN         = !w_fwd_wr;
        ramaddr        = w_fwd_wr ? '0 : daddr[r_sup];
        ramstore       = w_fwd_wr ? '0 : dstore[r_sup];
        dwait[r_grant] = !w_done;
        dwait[r_sup]   = !w_done;
      end
      WB: begin
        ramWEN         = 1'b1;
        ramaddr        = daddr[r_grant];
        ramstore       = dstore[r_grant];
        dwait[r_grant] = !w_access;
      end
      default: ;
    endcase
  end
endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
- N-core MSI snooping bus controller between the private L1 data caches and the single shared memory port.
- Serialises coherence transactions with a round-robin arbiter and broadcasts snoops to every non-requesting cache.
- Moves BLK_WORDS-word blocks by one of three paths: memory load, cache-to-cache forward (with memory update on read-share), or eviction writeback.
- Parametrised in core count, block size and snoop-response latency.

Parameters:
- NCPU, 2, number of cores/caches (2..8); IDW = $clog2(NCPU), minimum 1.
- BLK_WORDS, 2, 32-bit words per cache block (1..8); CW = $clog2(BLK_WORDS), minimum 1.
- SNP_LAT, 2, cycles snooped caches get before responses are sampled (1..7).

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous reset, active-low.
- dREN  in  NCPU  per-cache block read request.
- dWEN  in  NCPU  per-cache writeback request.
- daddr  in  NCPU x 32  per-cache word address.
- dstore  in  NCPU x 32  per-cache store / supply data.
- cctrans  in  NCPU  request or snoop-hit-on-M flag.
- ccwrite  in  NCPU  requester intends to write (BusRdX/upgrade).
- ramload  in  32  memory read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- dwait  out  NCPU  per-cache wait; 0 = word accepted/valid this cycle.
- dload  out  NCPU x 32  per-cache load data.
- ccwait  out  NCPU  cache is being snooped; hold.
- ccinv  out  NCPU  invalidate snooped line.
- ccsnoopaddr  out  NCPU x 32  snoop address, all = daddr[grant].
- ramREN  out  1  memory read enable.
- ramWEN  out  1  memory write enable.
- ramaddr  out  32  memory address.
- ramstore  out  32  memory write data.

Behaviour:
- Reset (async, nRST=0): state IDLE, grant=0, rr_ptr=0, wcnt=0, sup=0. Outputs: dwait all 1; all other outputs 0 except ccsnoopaddr, which stays combinational = daddr[grant].
- Reset mid-transaction aborts it; memory may hold a partial block, which is acceptable.
- Registered state: state, grant, rr_ptr, wcnt (word counter), sup (supplier id), snp_cnt.
- IDLE, arbitration:
  - Requesters = cctrans & (dREN | dWEN | ccwrite).
  - Grant the first requester found searching from rr_ptr upward, modulo NCPU; on grant, rr_ptr <= grant+1 mod NCPU.
  - Next state: dWEN -> WB; else dREN -> SNOOP; else (ccwrite, upgrade S->M) -> INV.
  - No requester: stay IDLE, all dwait=1.
- INV (1 cycle): ccinv[j]=1 for all j != grant; -> IDLE. No memory access.
- SNOOP (SNP_LAT+1 cycles, counted by snp_cnt):
  - Every cycle: ccwait[j]=1 and ccinv[j]=ccwrite[grant] for all j != grant.
  - Last cycle: if any j != grant has cctrans[j], sup <= lowest such j and go to FWD; else go to LOAD.
- LOAD:
  - ccwait to others held; ramREN=1, ramaddr=daddr[grant], dload[grant]=ramload, dwait[grant]=(ramstate!=ACCESS).
  - Each ACCESS completes a word and increments wcnt; ACCESS with wcnt==BLK_WORDS-1 -> IDLE and wcnt<=0.
- FWD:
  - dload[grant]=dstore[sup].
  - Read (ccwrite[grant]=0): ramWEN=1, ramaddr=daddr[sup], ramstore=dstore[sup]; dwait[grant] and dwait[sup] drop together only on ACCESS. The M->S downgrade updates memory.
  - Write (ccwrite[grant]=1): no memory access; dwait[grant] and dwait[sup] = 0 every cycle, one word per cycle.
  - Word counting and exit as in LOAD.
- WB: ramWEN=1, ramaddr=daddr[grant], ramstore=dstore[grant], dwait[grant]=(ramstate!=ACCESS); counting and exit as in LOAD.
- ramstate ERROR or BUSY: word not completed, hold state and outputs (retry).
- New requests are ignored outside IDLE; a cache's own cctrans while it is snooped counts only as a response.
- Each dwait=0 pulse is exactly one cycle per word. No idle gap between words; the cache advances daddr in the cycle after a completed word.
- BLK_WORDS=1: a single completion exits.

Decomposition:
- cpu_types_pkg gains coh_state_t (IDLE, INV, SNOOP, LOAD, FWD, WB) and reuses ramstate_t and word_t.
- One sub-module, rr_arbiter (NCPU wide: req, ptr in; grant id, valid out; pure combinational priority rotate), instantiated once.

Test Plan:
- Cold read: cache0 dREN+cctrans, daddr=0x100, no snoop hit, ramstate ACCESS after 2 BUSY per word -> 2 LOAD words to dload[0]; ccwait[1]=1 throughout; IDLE after 2nd ACCESS.
- Read-share from M: cache1 holds 0x200 in M and answers cctrans[1]=1 in SNOOP; cache0 reads -> FWD read: dload[0]=dstore[1], ramWEN=1 with ramaddr=0x200 then 0x204, dwait[0]/dwait[1] low only on ACCESS.
- Write miss on M copy: cache0 ccwrite=1, cache1 hit -> ccinv[1]=1 during SNOOP; FWD with ramWEN=0; 2 consecutive cycles dwait[0]=0.
- Upgrade: cache1 cctrans+ccwrite, no dREN/dWEN -> exactly 1 cycle ccinv[0]=1, no ram enables, back to IDLE.
- Fairness, NCPU=4: all four assert cctrans+dWEN continuously -> grants 0,1,2,3,0 in order; each WB writes BLK_WORDS words.
- Reset mid-LOAD: nRST low after 1st word -> immediately dwait=all 1, ramREN=0, state IDLE; next request starts at wcnt=0.
